// File: rtl/li_seq_unit.sv
// li_seq_unit: load-immediate sequencer (lane insert/clear, multi-chunk build).
// Ports: clk, rst_n, flush, op_* request, wb_* writeback, err; LI_SEQ_SIGN_EXT_EN adds op_sext.
module li_seq_unit #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int REG_AW = 3,
  localparam int LANES = DATA_W / IMM_W,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_mode,
  input  logic [LW-1:0]     op_lane,
  input  logic [IMM_W-1:0]  op_imm,
  input  logic [REG_AW-1:0] op_rt,
  input  logic [DATA_W-1:0] old_rt,
`ifdef LI_SEQ_SIGN_EXT_EN
  input  logic              op_sext,
`endif
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    WB
  } state_t;

  state_t            state;
  logic              rdy_q;
  logic [DATA_W-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;

  logic sext;
`ifdef LI_SEQ_SIGN_EXT_EN
  assign sext = op_sext;
`else
  assign sext = 1'b0;
`endif

  // Flush must block acceptance in the same cycle it is raised.
  assign op_ready = rdy_q & ~flush;

  logic take;
  assign take = op_valid & op_ready;

  logic is_ins, is_clr, is_start, is_next;
  assign is_ins   = (op_mode == 2'd0);
  assign is_clr   = (op_mode == 2'd1);
  assign is_start = (op_mode == 2'd2);
  assign is_next  = (op_mode == 2'd3);

  logic lane_ok;
  assign lane_ok = int'(op_lane) < LANES;

  logic [IMM_W-1:0] fill;
  assign fill = {IMM_W{sext & op_imm[IMM_W-1]}};

  logic [DATA_W-1:0] ins_val;
  logic [DATA_W-1:0] clr_val;
  logic [DATA_W-1:0] start_val;
  logic [DATA_W-1:0] next_acc;

  always_comb begin
    ins_val   = old_rt;
    clr_val   = '0;
    start_val = '0;
    for (int l = 0; l < LANES; l++) begin
      if (int'(op_lane) == l) begin
        ins_val[l*IMM_W +: IMM_W] = op_imm;
        clr_val[l*IMM_W +: IMM_W] = op_imm;
      end else if (int'(op_lane) < l) begin
        clr_val[l*IMM_W +: IMM_W] = fill;
      end
      start_val[l*IMM_W +: IMM_W] = (l == 0) ? op_imm : fill;
    end
    next_acc = (acc << IMM_W) | DATA_W'(op_imm);
  end

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      err <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        rdy_q    <= 1'b1;
        wb_valid <= 1'b0;
        acc      <= '0;
        cnt      <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            rdy_q <= 1'b1;
            if (take) begin
              unique case (1'b1)
                is_ins, is_clr: begin
                  if (!lane_ok) begin
                    err <= 1'b1;
                  end else begin
                    wb_data  <= is_ins ? ins_val : clr_val;
                    wb_addr  <= op_rt;
                    wb_valid <= 1'b1;
                    rdy_q    <= 1'b0;
                    state    <= WB;
                  end
                end
                is_start: begin
                  wb_addr <= op_rt;
                  if (LANES == 1) begin
                    wb_data  <= start_val;
                    wb_valid <= 1'b1;
                    rdy_q    <= 1'b0;
                    state    <= WB;
                    acc      <= '0;
                    cnt      <= '0;
                  end else begin
                    acc   <= start_val;
                    cnt   <= CW'(1);
                    state <= BUILD;
                  end
                end
                is_next: begin
                  err <= 1'b1;
                  acc <= '0;
                  cnt <= '0;
                end
                default: ;
              endcase
            end
          end
          BUILD: begin
            rdy_q <= 1'b1;
            if (take) begin
              if (is_next) begin
                if (cnt_inc == CW'(LANES)) begin
                  wb_data  <= next_acc;
                  wb_valid <= 1'b1;
                  rdy_q    <= 1'b0;
                  state    <= WB;
                  acc      <= '0;
                  cnt      <= '0;
                end else begin
                  acc <= next_acc;
                  cnt <= cnt_inc;
                end
              end else begin
                err   <= 1'b1;
                acc   <= '0;
                cnt   <= '0;
                state <= IDLE;
              end
            end
          end
          WB: begin
            if (wb_ready) begin
              wb_valid <= 1'b0;
              rdy_q    <= 1'b1;
              state    <= IDLE;
            end else begin
              rdy_q <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_li_seq_unit.sv
// tb_li_seq_unit: scoreboard bench for li_seq_unit.
// Directed scenarios plus random ops against a chunk-level model.
module tb_li_seq_unit;
  localparam int DW = 16;
  localparam int IW = 8;
  localparam int AW = 3;
  localparam int LN = DW / IW;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;
`ifdef LI_SEQ_SIGN_EXT_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic flush = 1'b0;
  logic op_valid = 1'b0;
  logic op_ready;
  logic [1:0] op_mode = '0;
  logic [LW-1:0] op_lane = '0;
  logic [IW-1:0] op_imm = '0;
  logic [AW-1:0] op_rt = '0;
  logic [DW-1:0] old_rt = '0;
  logic op_sext = 1'b0;
  logic wb_valid;
  logic wb_ready = 1'b0;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  li_seq_unit #(.DATA_W(DW), .IMM_W(IW), .REG_AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_mode(op_mode),
    .op_lane(op_lane),
    .op_imm(op_imm),
    .op_rt(op_rt),
    .old_rt(old_rt),
`ifdef LI_SEQ_SIGN_EXT_EN
    .op_sext(op_sext),
`endif
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .err(err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wb_t;

  wb_t sb[$];

  typedef enum {M_IDLE, M_BUILD, M_WB} mst_t;
  mst_t mst = M_IDLE;
  int chunks[$];
  logic [AW-1:0] m_rt = '0;
  bit m_live = 1'b0;
  bit exp_ready = 1'b0;
  bit exp_wbv = 1'b0;
  bit exp_err = 1'b0;
  bit mon_en = 1'b0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle flags plus scoreboard on presented writebacks.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("op_ready", 32'(op_ready), 32'(exp_ready));
      chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
      chk("err", 32'(err), 32'(exp_err));
      if (wb_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got addr %0h data %0h expected none",
                   wb_addr, wb_data);
        end else begin
          chk("wb_addr", 32'(wb_addr), 32'(sb[0].a));
          chk("wb_data", 32'(wb_data), 32'(sb[0].d));
          if (wb_ready && !flush) void'(sb.pop_front());
        end
      end
    end
  end

  function automatic logic [DW-1:0] lane_val();
    int ln;
    logic [DW-1:0] mask;
    logic [DW-1:0] v;
    ln = int'(op_lane);
    mask = DW'((1 << IW) - 1) << (ln * IW);
    v = DW'(op_imm) << (ln * IW);
    if (op_mode == 2'd0) return (old_rt & ~mask) | v;
    if (SEXT && op_sext && op_imm[IW-1])
      v = v | ({DW{1'b1}} << ((ln + 1) * IW));
    return v;
  endfunction

  task automatic push_wb(logic [AW-1:0] a, logic [DW-1:0] d);
    wb_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
    mst = M_WB;
  endtask

  task automatic finish_build();
    logic [DW-1:0] v;
    v = '0;
    foreach (chunks[i]) v = v | (DW'(chunks[i]) << ((LN - 1 - i) * IW));
    chunks.delete();
    push_wb(m_rt, v);
  endtask

  task automatic bad();
    exp_err = 1'b1;
    mst = M_IDLE;
    chunks.delete();
  endtask

  // Advance the model by the edge that just happened with current inputs.
  task automatic model_step();
    bit acc;
    acc = op_valid && exp_ready;
    exp_err = 1'b0;
    if (flush) begin
      mst = M_IDLE;
      chunks.delete();
      sb.delete();
    end else if (mst == M_WB) begin
      if (wb_ready) mst = M_IDLE;
    end else if (acc) begin
      case (op_mode)
        2'd0, 2'd1: begin
          if (mst == M_BUILD) bad();
          else if (int'(op_lane) >= LN) exp_err = 1'b1;
          else push_wb(op_rt, lane_val());
        end
        2'd2: begin
          if (mst == M_BUILD) bad();
          else begin
            chunks.delete();
            chunks.push_back(int'(op_imm));
            m_rt = op_rt;
            if (LN == 1) finish_build();
            else mst = M_BUILD;
          end
        end
        default: begin
          if (mst == M_IDLE) bad();
          else begin
            chunks.push_back(int'(op_imm));
            if (chunks.size() == LN) finish_build();
          end
        end
      endcase
    end
    m_live = 1'b1;
    exp_wbv = (mst == M_WB);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic cyc(bit v, int m, int ln, int imm, int rt, int old,
                     bit wr, bit fl, bit sx);
    op_valid = v;
    op_mode = 2'(m);
    op_lane = LW'(ln);
    op_imm = IW'(imm);
    op_rt = AW'(rt);
    old_rt = DW'(old);
    wb_ready = wr;
    flush = fl;
    op_sext = sx;
    exp_ready = m_live && (mst != M_WB) && !fl;
    tick();
  endtask

  task automatic idle(bit wr);
    cyc(0, 0, 0, 0, 0, 0, wr, 0, 0);
  endtask

  task automatic chk_zero_outs(string n);
    chk({n, "_op_ready"}, 32'(op_ready), 32'd0);
    chk({n, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({n, "_wb_addr"}, 32'(wb_addr), 32'd0);
    chk({n, "_wb_data"}, 32'(wb_data), 32'd0);
    chk({n, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_zero_outs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("release_ready", 32'(op_ready), 32'd1);
    mon_en = 1'b1;

    // Lane insert, lane 0.
    cyc(1, 0, 0, 'h5A, 5, 'h1234, 0, 0, 0);
    chk("ins_valid", 32'(wb_valid), 32'd1);
    chk("ins_addr", 32'(wb_addr), 32'd5);
    chk("ins_data", 32'(wb_data), 32'h125A);
    idle(1);
    chk("ins_done", 32'(wb_valid), 32'd0);

    // Lane clear, lane 1.
    cyc(1, 1, 1, 'hAB, 3, 'hFFFF, 0, 0, 0);
    chk("clr_data", 32'(wb_data), 32'hAB00);
    idle(1);
`ifdef LI_SEQ_SIGN_EXT_EN
    cyc(1, 1, 0, 'h80, 4, 0, 0, 0, 1);
    chk("clr_sext_data", 32'(wb_data), 32'hFF80);
    idle(1);
`endif

    // Two-chunk build with stalled writeback.
    cyc(1, 2, 0, 'h12, 2, 0, 0, 0, 0);
    cyc(1, 3, 0, 'h34, 7, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk("build_hold_data", 32'(wb_data), 32'h1234);
      chk("build_hold_addr", 32'(wb_addr), 32'd2);
      chk("build_hold_ready", 32'(op_ready), 32'd0);
    end
    idle(1);
    chk("build_idle_valid", 32'(wb_valid), 32'd0);
    chk("build_idle_ready", 32'(op_ready), 32'd1);

    // Illegal sequences.
    cyc(1, 3, 0, 'h11, 1, 0, 0, 0, 0);
    chk("next_in_idle_err", 32'(err), 32'd1);
    idle(0);
    chk("err_one_cycle", 32'(err), 32'd0);
    cyc(1, 2, 0, 'h22, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 'h33, 1, 'h4444, 0, 0, 0);
    chk("ins_in_build_err", 32'(err), 32'd1);
    idle(0);
    chk("ins_in_build_err_end", 32'(err), 32'd0);

    // Reset in the middle of a build.
    cyc(1, 2, 0, 'h77, 6, 0, 0, 0, 0);
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero_outs("midbuild_reset");
    mst = M_IDLE;
    chunks.delete();
    sb.delete();
    m_live = 1'b0;
    exp_ready = 1'b0;
    exp_wbv = 1'b0;
    exp_err = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("midbuild_release_ready", 32'(op_ready), 32'd1);

    // Flush with a simultaneous op, and flush during writeback.
    cyc(1, 0, 0, 'h01, 1, 0, 0, 1, 0);
    chk("flush_op_valid", 32'(wb_valid), 32'd0);
    chk("flush_op_err", 32'(err), 32'd0);
    cyc(1, 1, 0, 'h02, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("flush_wb_valid", 32'(wb_valid), 32'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int m;
      if (mst == M_BUILD && $urandom_range(3) != 0) m = 3;
      else m = int'($urandom_range(3));
      cyc(($urandom_range(3) != 0), m, int'($urandom_range(LN - 1)),
          int'($urandom), int'($urandom), int'($urandom),
          ($urandom_range(2) != 0), ($urandom_range(39) == 0),
          1'($urandom));
    end

    for (int n = 0; n < 4; n++) idle(1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
